// File: rtl/lenet_weight_loader.sv
// Weight/bias loader for the LeNet-5 core: looks up a per-layer descriptor, streams
// weight bytes then little-endian bias words from weight memory into the weight buffer.
module lenet_weight_loader #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned BIAS_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned NUM_ENTRIES     = 16
) (
  input  logic              clk_i,
  input  logic              rst_sync_n_i,
  input  logic              tbl_we_i,
  input  logic [3:0]        tbl_idx_i,
  input  logic [ADDR_W-1:0] tbl_wbase_i,
  input  logic [15:0]       tbl_wlen_i,
  input  logic [7:0]        tbl_blen_i,
  input  logic              req_load_weight_i,
  input  logic [3:0]        layer_id_i,
  output logic              weight_loaded_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              wbuf_we_o,
  output logic              wbuf_sel_o,
  output logic [15:0]       wbuf_addr_o,
  output logic [BIAS_W-1:0] wbuf_data_o
);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SH_W  = BIAS_W - DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FETCH, S_DRAIN, S_DONE, S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tbl_wbase_q [NUM_ENTRIES];
  logic [ADDR_W-1:0] tbl_wbase_d [NUM_ENTRIES];
  logic [15:0]       tbl_wlen_q  [NUM_ENTRIES];
  logic [15:0]       tbl_wlen_d  [NUM_ENTRIES];
  logic [7:0]        tbl_blen_q  [NUM_ENTRIES];
  logic [7:0]        tbl_blen_d  [NUM_ENTRIES];
  logic [3:0]        layer_q, layer_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [15:0]       wlen_q, wlen_d;
  logic [16:0]       total_q, total_d;
  logic [16:0]       issued_q, issued_d;
  logic [16:0]       received_q, received_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [SH_W-1:0]   bias_sh_q, bias_sh_d;
  logic              err_q, err_d;
  logic              wbuf_we_q, wbuf_we_d;
  logic              wbuf_sel_q, wbuf_sel_d;
  logic [15:0]       wbuf_addr_q, wbuf_addr_d;
  logic [BIAS_W-1:0] wbuf_data_q, wbuf_data_d;
  logic              mem_req;
  logic              issue;
  logic              rx;
  logic [16:0]       boff;

  always_comb begin
    state_d       = state_q;
    tbl_wbase_d   = tbl_wbase_q;
    tbl_wlen_d    = tbl_wlen_q;
    tbl_blen_d    = tbl_blen_q;
    layer_d       = layer_q;
    wbase_d       = wbase_q;
    wlen_d        = wlen_q;
    total_d       = total_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    bias_sh_d     = bias_sh_q;
    err_d         = err_q;
    wbuf_we_d     = 1'b0;
    wbuf_sel_d    = wbuf_sel_q;
    wbuf_addr_d   = wbuf_addr_q;
    wbuf_data_d   = wbuf_data_q;
    mem_req       = 1'b0;
    boff          = received_q - {1'b0, wlen_q};
    rx            = mem_rvalid_i && (state_q == S_FETCH || state_q == S_DRAIN)
                    && (received_q < total_q);

    if (tbl_we_i) begin
      tbl_wbase_d[tbl_idx_i] = tbl_wbase_i;
      tbl_wlen_d[tbl_idx_i]  = tbl_wlen_i;
      tbl_blen_d[tbl_idx_i]  = tbl_blen_i;
    end

    case (state_q)
      S_IDLE: begin
        if (req_load_weight_i) begin
          layer_d = layer_id_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        wbase_d       = tbl_wbase_q[layer_q];
        wlen_d        = tbl_wlen_q[layer_q];
        total_d       = {1'b0, tbl_wlen_q[layer_q]} + {7'b0, tbl_blen_q[layer_q], 2'b00};
        issued_d      = '0;
        received_d    = '0;
        outstanding_d = '0;
        if (total_d == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req = (issued_q < total_q) && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
        if (issued_q == total_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (received_q + 17'(rx) == total_q) state_d = S_DONE;
      end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!req_load_weight_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    issue = mem_req && mem_gnt_i;
    if (issue) issued_d = issued_q + 17'd1;
    outstanding_d = outstanding_d + OUT_W'(issue) - OUT_W'(rx);

    // Return index decides the target: first wlen bytes are weights, the rest pack into biases.
    if (rx) begin
      received_d = received_q + 17'd1;
      if (received_q < {1'b0, wlen_q}) begin
        wbuf_we_d   = 1'b1;
        wbuf_sel_d  = 1'b0;
        wbuf_addr_d = received_q[15:0];
        wbuf_data_d = BIAS_W'(mem_rdata_i);
      end else if (boff[1:0] == 2'd3) begin
        wbuf_we_d   = 1'b1;
        wbuf_sel_d  = 1'b1;
        wbuf_addr_d = 16'(boff >> 2);
        wbuf_data_d = {mem_rdata_i, bias_sh_q};
      end else begin
        bias_sh_d = {mem_rdata_i, bias_sh_q[SH_W-1:DATA_W]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      state_q       <= S_IDLE;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        tbl_wbase_q[i] <= '0;
        tbl_wlen_q[i]  <= '0;
        tbl_blen_q[i]  <= '0;
      end
      layer_q       <= '0;
      wbase_q       <= '0;
      wlen_q        <= '0;
      total_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      bias_sh_q     <= '0;
      err_q         <= 1'b0;
      wbuf_we_q     <= 1'b0;
      wbuf_sel_q    <= 1'b0;
      wbuf_addr_q   <= '0;
      wbuf_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      tbl_wbase_q   <= tbl_wbase_d;
      tbl_wlen_q    <= tbl_wlen_d;
      tbl_blen_q    <= tbl_blen_d;
      layer_q       <= layer_d;
      wbase_q       <= wbase_d;
      wlen_q        <= wlen_d;
      total_q       <= total_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      bias_sh_q     <= bias_sh_d;
      err_q         <= err_d;
      wbuf_we_q     <= wbuf_we_d;
      wbuf_sel_q    <= wbuf_sel_d;
      wbuf_addr_q   <= wbuf_addr_d;
      wbuf_data_q   <= wbuf_data_d;
    end
  end

  assign weight_loaded_o = (state_q == S_DONE);
  assign busy_o          = (state_q != S_IDLE);
  assign err_o           = err_q;
  assign mem_req_o       = mem_req;
  assign mem_addr_o      = mem_req ? wbase_q + ADDR_W'(issued_q) : '0;
  assign wbuf_we_o       = wbuf_we_q;
  assign wbuf_sel_o      = wbuf_sel_q;
  assign wbuf_addr_o     = wbuf_addr_q;
  assign wbuf_data_o     = wbuf_data_q;
endmodule

// File: tb/tb_lenet_weight_loader.sv
// Bench for lenet_weight_loader: in-order memory model with random grant/latency and a
// descriptor-level reference for the expected read and write streams.
module tb_lenet_weight_loader;
  logic        clk_i = 1'b0;
  logic        rst_sync_n_i = 1'b0;
  logic        tbl_we_i = 1'b0;
  logic [3:0]  tbl_idx_i = '0;
  logic [15:0] tbl_wbase_i = '0;
  logic [15:0] tbl_wlen_i = '0;
  logic [7:0]  tbl_blen_i = '0;
  logic        req_load_weight_i = 1'b0;
  logic [3:0]  layer_id_i = '0;
  logic        weight_loaded_o, busy_o, err_o, mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        wbuf_we_o, wbuf_sel_o;
  logic [15:0] wbuf_addr_o;
  logic [31:0] wbuf_data_o;

  lenet_weight_loader #(
    .ADDR_W(16), .DATA_W(8), .BIAS_W(32), .MAX_OUTSTANDING(4), .NUM_ENTRIES(16)
  ) dut (
    .clk_i(clk_i), .rst_sync_n_i(rst_sync_n_i),
    .tbl_we_i(tbl_we_i), .tbl_idx_i(tbl_idx_i), .tbl_wbase_i(tbl_wbase_i),
    .tbl_wlen_i(tbl_wlen_i), .tbl_blen_i(tbl_blen_i),
    .req_load_weight_i(req_load_weight_i), .layer_id_i(layer_id_i),
    .weight_loaded_o(weight_loaded_o), .busy_o(busy_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wbuf_we_o(wbuf_we_o), .wbuf_sel_o(wbuf_sel_o), .wbuf_addr_o(wbuf_addr_o),
    .wbuf_data_o(wbuf_data_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct { logic [15:0] addr; int unsigned ready; } rd_t;
  typedef struct { logic sel; logic [15:0] addr; logic [31:0] data; int unsigned cyc; } wr_t;

  logic [7:0]  mem_b [0:65535];
  rd_t         rq[$];
  logic [15:0] rd_addr_q[$];
  int unsigned rv_cyc[$];
  wr_t         wr_q[$];
  bit          gnt_rand = 1'b0;
  bit          lat_rand = 1'b0;
  int unsigned ncyc = 0, last_ready = 0, grant_total = 0, max_out = 0;
  int unsigned pulse_cnt = 0, pulse_cyc = 0;
  int unsigned n_vec = 0, n_err = 0;

  // Memory model and monitor: observes at the falling edge, drives the next rising edge.
  initial begin
    rd_t         rd;
    int unsigned rdy;
    forever begin
      @(negedge clk_i);
      ncyc++;
      if (wbuf_we_o) wr_q.push_back('{wbuf_sel_o, wbuf_addr_o, wbuf_data_o, ncyc});
      if (weight_loaded_o) begin
        pulse_cnt++;
        pulse_cyc = ncyc;
      end
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (rq.size() > 0 && rq[0].ready <= ncyc) begin
        rd = rq.pop_front();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_b[rd.addr];
        rv_cyc.push_back(ncyc);
      end
      mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req_o && mem_gnt_i) begin
        rdy = ncyc + (lat_rand ? $urandom_range(1, 6) : 2);
        if (rdy <= last_ready) rdy = last_ready + 1;
        last_ready = rdy;
        rq.push_back('{mem_addr_o, rdy});
        rd_addr_q.push_back(mem_addr_o);
        grant_total++;
      end
      if (rq.size() > max_out) max_out = rq.size();
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic prog(input logic [3:0] idx, input logic [15:0] base,
                      input logic [15:0] wlen, input logic [7:0] blen);
    tbl_we_i = 1'b1; tbl_idx_i = idx; tbl_wbase_i = base; tbl_wlen_i = wlen; tbl_blen_i = blen;
    tick();
    tbl_we_i = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_loaded"}, weight_loaded_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_mem_req"}, mem_req_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_wbuf_we"}, wbuf_we_o, 0);
    check({tag, "_wbuf_sel"}, wbuf_sel_o, 0);
    check({tag, "_wbuf_addr"}, wbuf_addr_o, 0);
    check({tag, "_wbuf_data"}, wbuf_data_o, 0);
  endtask

  task automatic release_req();
    req_load_weight_i = 1'b0;
    tick();
    tick();
    check("idle_after_release", busy_o, 0);
  endtask

  task automatic run_load(input logic [3:0] layer, input logic [15:0] base,
                          input logic [15:0] wlen, input logic [7:0] blen, input bit rnd,
                          input bit clobber, input logic [15:0] cb, input logic [15:0] cw,
                          input logic [7:0] cbl);
    int unsigned tot, nw, bound;
    logic [31:0] word;
    rd_addr_q.delete(); rv_cyc.delete(); wr_q.delete();
    pulse_cnt = 0; max_out = 0;
    gnt_rand = rnd; lat_rand = rnd;
    req_load_weight_i = 1'b1;
    layer_id_i = layer;
    tick();
    layer_id_i = 4'($urandom);
    if (clobber) begin
      tbl_we_i = 1'b1; tbl_idx_i = layer; tbl_wbase_i = cb; tbl_wlen_i = cw; tbl_blen_i = cbl;
    end
    tick();
    tbl_we_i = 1'b0;
    bound = 0;
    while (pulse_cnt == 0 && bound < 5000) begin
      tick();
      bound++;
    end
    check("load_completes", pulse_cnt != 0, 1);
    tick();
    tick();
    tot = wlen + 4 * blen;
    check("read_count", rd_addr_q.size(), tot);
    for (int i = 0; i < rd_addr_q.size() && i < tot; i++)
      check("read_addr", rd_addr_q[i], 16'(base + i));
    nw = wr_q.size();
    check("write_count", nw, wlen + blen);
    for (int i = 0; i < wlen && i < nw; i++) begin
      check("weight_write", {wr_q[i].sel, wr_q[i].addr, wr_q[i].data},
            {1'b0, 16'(i), 24'h0, mem_b[16'(base + i)]});
      if (i < rv_cyc.size()) check("weight_latency", wr_q[i].cyc, rv_cyc[i] + 1);
    end
    for (int k = 0; k < blen && wlen + k < nw; k++) begin
      word = '0;
      for (int j = 0; j < 4; j++) word |= 32'(mem_b[16'(base + wlen + 4 * k + j)]) << (8 * j);
      check("bias_write", {wr_q[wlen+k].sel, wr_q[wlen+k].addr, wr_q[wlen+k].data},
            {1'b1, 16'(k), word});
      if (wlen + 4 * k + 3 < rv_cyc.size())
        check("bias_latency", wr_q[wlen+k].cyc, rv_cyc[wlen + 4 * k + 3] + 1);
    end
    if (nw > 0) check("done_not_before_last_write", pulse_cyc >= wr_q[nw-1].cyc, 1);
    check("single_pulse", pulse_cnt, 1);
    check("outstanding_bound", max_out <= 4, 1);
    check("busy_in_release", busy_o, 1);
  endtask

  initial begin
    int unsigned snap, snap_w, bound;
    logic [15:0] b2, w2, cb2, cw2;
    logic [7:0]  bl2, cbl2;
    logic [15:0] wrap_exp [4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 65536; i++) mem_b[i] = 8'($urandom);
    mem_b[16'h2000] = 8'h78; mem_b[16'h2001] = 8'h56;
    mem_b[16'h2002] = 8'h34; mem_b[16'h2003] = 8'h12;

    repeat (3) tick();
    check_quiet("reset");
    rst_sync_n_i = 1'b1;
    tick();

    b2 = 16'($urandom); w2 = 16'($urandom_range(1, 30)); bl2 = 8'($urandom_range(0, 3));
    cb2 = 16'($urandom); cw2 = 16'($urandom_range(1, 30)); cbl2 = 8'($urandom_range(1, 3));
    prog(4'd1, 16'h0100, 16'd150, 8'd6);
    prog(4'd2, b2, w2, bl2);
    prog(4'd5, 16'h0, 16'd0, 8'd0);
    prog(4'd7, 16'h2000, 16'd0, 8'd1);
    prog(4'd9, 16'hFFFE, 16'd4, 8'd0);

    // Fixed latency, full grant; then hold the request after completion.
    run_load(4'd1, 16'h0100, 16'd150, 8'd6, 1'b0, 1'b0, '0, '0, '0);
    check("last_read_addr", rd_addr_q.size() > 0 ? rd_addr_q[rd_addr_q.size()-1] : 16'h0, 16'h01AD);
    snap = grant_total;
    repeat (20) tick();
    check("held_req_no_reads", grant_total - snap, 0);
    check("held_req_no_pulse", pulse_cnt, 1);
    check("held_req_busy", busy_o, 1);
    release_req();

    run_load(4'd1, 16'h0100, 16'd150, 8'd6, 1'b1, 1'b0, '0, '0, '0);
    release_req();
    check("err_clear_before_empty", err_o, 0);

    // Empty descriptor.
    gnt_rand = 1'b0;
    snap = grant_total; wr_q.delete(); pulse_cnt = 0;
    req_load_weight_i = 1'b1; layer_id_i = 4'd5;
    tick();
    check("empty_lookup_no_pulse", weight_loaded_o, 0);
    check("empty_lookup_busy", busy_o, 1);
    tick();
    check("empty_pulse_latency", weight_loaded_o, 1);
    check("empty_err", err_o, 1);
    tick();
    check("empty_pulse_one_cycle", weight_loaded_o, 0);
    check("empty_no_reads", grant_total - snap, 0);
    check("empty_no_writes", wr_q.size(), 0);
    check("empty_single_pulse", pulse_cnt, 1);
    release_req();
    check("err_sticky", err_o, 1);

    run_load(4'd7, 16'h2000, 16'd0, 8'd1, 1'b1, 1'b0, '0, '0, '0);
    check("bias_word_const", wr_q.size() > 0 ? {wr_q[0].sel, wr_q[0].addr, wr_q[0].data} : 49'h0,
          {1'b1, 16'h0, 32'h12345678});
    release_req();

    run_load(4'd9, 16'hFFFE, 16'd4, 8'd0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) check("wrap_addr", rd_addr_q[i], wrap_exp[i]);
    release_req();

    // Same-cycle table write of the index under lookup: old entry used, new one next time.
    run_load(4'd2, b2, w2, bl2, 1'b1, 1'b1, cb2, cw2, cbl2);
    release_req();
    run_load(4'd2, cb2, cw2, cbl2, 1'b1, 1'b0, '0, '0, '0);
    release_req();

    // Reset in the middle of a fetch.
    gnt_rand = 1'b0; lat_rand = 1'b1;
    snap = grant_total;
    req_load_weight_i = 1'b1; layer_id_i = 4'd1;
    bound = 0;
    while (grant_total < snap + 5 && bound < 100) begin
      tick();
      bound++;
    end
    check("fetch_started", grant_total >= snap + 5, 1);
    rst_sync_n_i = 1'b0; req_load_weight_i = 1'b0;
    tick();
    check_quiet("mid_fetch_reset");
    rst_sync_n_i = 1'b1;
    snap_w = wr_q.size();
    snap = grant_total;
    repeat (12) tick();
    check("late_rvalid_no_writes", wr_q.size() - snap_w, 0);
    check("post_reset_no_reads", grant_total - snap, 0);
    check("post_reset_idle", busy_o, 0);

    req_load_weight_i = 1'b1; layer_id_i = 4'd1;
    tick();
    tick();
    check("table_cleared_pulse", weight_loaded_o, 1);
    check("table_cleared_err", err_o, 1);
    check("table_cleared_no_reads", grant_total - snap, 0);
    release_req();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lenet_weight_loader.md
Name: lenet_weight_loader

Overview:
- Services the LeNet-5 sequencer's weight-load handshake (req_load_weight / layer_id / weight_loaded).
- On each request, looks up a host-programmed per-layer descriptor and streams the weight bytes, then the bias bytes, from weight memory.
- Writes weights into the systolic array's weight buffer as bytes, and writes biases as 32-bit words.
- Sits between the layer sequencer, the weight memory read port and the core's weight/bias buffer.

Parameters:
- ADDR_W, 16, weight-memory byte address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, weight-memory read data width (one int8 weight per beat).
- BIAS_W, 32, bias word width, assembled from 4 bytes.
- MAX_OUTSTANDING, 4, maximum memory reads issued but not yet returned.
- NUM_ENTRIES, 16, descriptor table depth, indexed by layer_id.

Ports:
- clk_i  in  1  clock.
- rst_sync_n_i  in  1  reset, synchronous, active-low.
- tbl_we_i  in  1  descriptor table write strobe.
- tbl_idx_i  in  4  descriptor index.
- tbl_wbase_i  in  ADDR_W  weight base byte address.
- tbl_wlen_i  in  16  number of weight bytes.
- tbl_blen_i  in  8  number of bias words.
- req_load_weight_i  in  1  load request, level, from the sequencer.
- layer_id_i  in  4  descriptor index to load.
- weight_loaded_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky; set by an empty descriptor, cleared only by reset.
- mem_req_o  out  1  read request.
- mem_addr_o  out  ADDR_W  read address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; responses return in order.
- mem_rdata_i  in  DATA_W  read data.
- wbuf_we_o  out  1  buffer write strobe.
- wbuf_sel_o  out  1  0 = weight write, 1 = bias write.
- wbuf_addr_o  out  16  weight index or bias index.
- wbuf_data_o  out  BIAS_W  write data; a weight is zero-extended into bits [7:0].

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; table entries 0.
  - Reset is honoured in any state, including mid-fetch.
  - Memory responses arriving after reset are ignored, because rvalid is accepted only in FETCH or DRAIN.
- Table write: any cycle, including while busy, takes effect on the next edge.
  - A write and a LOOKUP of the same index in the same cycle: LOOKUP returns the old value.
- FSM states: IDLE, LOOKUP, FETCH, DRAIN, DONE, RELEASE.
- IDLE: when req_load_weight_i=1, latch layer_id_i and go to LOOKUP. Later changes to layer_id_i are ignored until the next IDLE.
- LOOKUP (1 cycle): latch the entry's wbase, wlen and blen. Set total = wlen + 4*blen (17 bits).
  - If total == 0: set err_o and go to DONE.
  - Otherwise go to FETCH.
- FETCH: mem_req_o=1 while issued < total and outstanding < MAX_OUTSTANDING.
  - mem_addr_o = wbase + issued (mod 2^ADDR_W).
  - issued increments on mem_req_o & mem_gnt_i.
  - outstanding += (req & gnt) − rvalid; simultaneous issue and return leaves it unchanged.
  - When issued == total, go to DRAIN.
- DRAIN: mem_req_o=0. When received == total (counting the return that arrives this cycle), go to DONE.
- Data path, receive index r (0-based):
  - r < wlen: on the next cycle, wbuf_we_o=1, wbuf_sel_o=0, wbuf_addr_o=r, wbuf_data_o={24'b0, byte}.
  - r ≥ wlen: bytes are packed little-endian. The cycle after the 4th byte of bias k: wbuf_we_o=1, wbuf_sel_o=1, wbuf_addr_o=k, wbuf_data_o=assembled word.
  - Write latency: exactly 1 cycle after the triggering rvalid.
- DONE (1 cycle): weight_loaded_o=1, then go to RELEASE.
  - DONE is entered only after the final wbuf write, or in the same cycle as it.
- RELEASE: stay until req_load_weight_i=0, then go to IDLE. A request held high after completion never triggers a second load.
- Latency: for an empty descriptor, weight_loaded_o is high 2 cycles after req is sampled in IDLE.

Test Plan:
- Table[1] = {base 0x0100, wlen 150, blen 6}, memory model latency 2, gnt always 1:
  - 174 reads at 0x0100..0x01AD.
  - 150 weight writes, addr 0..149, data = memory bytes.
  - 6 bias writes.
  - Exactly one weight_loaded_o pulse.
- Same load with random gnt (50%) and random latency 1–6: identical write stream, and outstanding never exceeds 4.
- Bias bytes 0x78, 0x56, 0x34, 0x12 → bias write data 0x12345678, sel=1, addr 0.
- Table[5] all zero, req with layer_id=5:
  - err_o=1.
  - weight_loaded_o high 2 cycles later.
  - No mem_req_o and no wbuf writes.
- Req held high for 20 cycles after completion → no new reads. Deassert, then reassert with layer_id=2 → loads entry 2.
- Boundary cases:
  - base 0xFFFE, wlen 4, blen 0 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Assert rst_sync_n_i=0 for 1 cycle mid-FETCH → all outputs 0 and state IDLE the next cycle. Late rvalids produce no writes.
